// File: rtl/mux_scan_ctrl.sv
// Sequencer for a 4:1 select mux: walks the enabled channels lowest-first, holds each
// select for DWELL cycles, then latches y into that channel's result bit.
module mux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       y,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic [3:0] valid
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]  mask_q;
  logic [1:0]  sel_q;
  logic        busy_q;
  logic        done_q;
  logic [3:0]  result_q;
  logic [3:0]  valid_q;

  logic [1:0]  first_sel_d;
  logic [1:0]  next_sel_d;
  logic        next_vld_d;

  // Lowest enabled channel of the incoming request.
  always_comb begin
    first_sel_d = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) first_sel_d = 2'(i);
    end
  end

  // Nearest latched channel strictly above the one currently selected.
  always_comb begin
    next_sel_d = sel_q;
    next_vld_d = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (2'(i) > sel_q)) begin
        next_sel_d = 2'(i);
        next_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mask_q   <= '0;
      sel_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            result_q <= '0;
            valid_q  <= '0;
            if (mask != 4'd0) begin
              mask_q  <= mask;
              sel_q   <= first_sel_d;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_SETTLE;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            result_q[sel_q] <= y;
            valid_q[sel_q]  <= 1'b1;
            cnt_q           <= '0;
            if (next_vld_d) begin
              sel_q <= next_sel_d;
            end else begin
              // Select stays on the last channel while idle.
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s0     = sel_q[0];
  assign s1     = sel_q[1];
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a schedule-based scan model checked every cycle, plus directed literals.
module tb_mux_scan_ctrl;

  localparam int DWELL = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] mask;
  logic       y;
  logic       s0, s1, busy, done;
  logic [3:0] result, valid;
  logic [3:0] inp;

  int vectors;
  int miscompares;
  int done_count;

  mux_scan_ctrl #(.DWELL(DWELL), .CW(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mask   (mask),
    .y      (y),
    .s0     (s0),
    .s1     (s1),
    .busy   (busy),
    .done   (done),
    .result (result),
    .valid  (valid)
  );

  // Mux stub: inp = {d,c,b,a}.
  assign y = inp[{s1, s0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a scan is the list of enabled channels; t counts edges since the start edge.
  bit         m_active;
  int         m_t;
  int         m_n;
  logic [1:0] m_ch [4];
  logic [1:0] e_sel;
  logic [3:0] e_res;
  logic [3:0] e_val;

  initial begin
    m_active = 0; m_t = 0; m_n = 0; e_sel = 0; e_res = 0; e_val = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 0; m_t = 0; m_n = 0; e_sel = 0; e_res = 0; e_val = 0;
      end else if (m_active) begin
        m_t++;
        if (m_t > m_n * DWELL) begin
          m_active = 0;
        end else begin
          if (m_t % DWELL == 0) begin
            int k;
            k = m_t / DWELL - 1;
            e_res[m_ch[k]] = inp[m_ch[k]];
            e_val[m_ch[k]] = 1'b1;
          end
          if (m_t < m_n * DWELL) e_sel = m_ch[m_t / DWELL];
        end
      end else if (start) begin
        m_n = 0;
        for (int i = 0; i < 4; i++) begin
          if (mask[i]) begin
            m_ch[m_n] = 2'(i);
            m_n++;
          end
        end
        m_t = 0; m_active = 1; e_res = 0; e_val = 0;
        if (m_n > 0) e_sel = m_ch[0];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("sel",    32'({s1, s0}), 32'(e_sel));
      chk("busy",   32'(busy),     32'(m_active && m_t < m_n * DWELL));
      chk("done",   32'(done),     32'(m_active && m_t == m_n * DWELL));
      chk("result", 32'(result),   32'(e_res));
      chk("valid",  32'(valid),    32'(e_val));
      if (done === 1'b1) done_count++;
    end
  end

  // Leaves the caller at the negedge right after start edge E.
  task automatic pulse_start(input logic [3:0] m);
    @(negedge clk);
    mask  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n), 32'(exp_cycles));
  endtask

  int dc0;

  initial begin
    vectors = 0; miscompares = 0; done_count = 0;
    rst_n = 1'b0; start = 1'b0; mask = 4'd0; inp = 4'b1101;
    repeat (2) @(negedge clk);
    chk("rst_sel",    32'({s1, s0}), 32'd0);
    chk("rst_busy",   32'(busy),     32'd0);
    chk("rst_done",   32'(done),     32'd0);
    chk("rst_result", 32'(result),   32'd0);
    chk("rst_valid",  32'(valid),    32'd0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: all channels
    pulse_start(4'b1111);
    wait_done("t1_done_lat", 16);
    chk("t1_result", 32'(result), 32'b1101);
    chk("t1_valid",  32'(valid),  32'b1111);
    chk("t1_sel",    32'({s1, s0}), 32'b11);
    repeat (3) @(negedge clk);

    // 2: channels a and c only
    pulse_start(4'b0101);
    wait_done("t2_done_lat", 8);
    chk("t2_result", 32'(result), 32'b0101);
    chk("t2_valid",  32'(valid),  32'b0101);
    repeat (3) @(negedge clk);

    // 3: empty mask
    pulse_start(4'b0000);
    wait_done("t3_done_lat", 0);
    chk("t3_valid", 32'(valid), 32'b0000);
    chk("t3_sel",   32'({s1, s0}), 32'b10);
    chk("t3_busy",  32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    // 4: single channel d, start re-pulsed mid-scan
    dc0 = done_count;
    pulse_start(4'b1000);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("t4_done_pulses", 32'(done_count - dc0), 32'd1);
    chk("t4_result3", 32'(result[3]), 32'd1);
    chk("t4_valid",   32'(valid), 32'b1000);
    chk("t4_sel",     32'({s1, s0}), 32'b11);

    // 5: a drops before its capture edge, recovers after it
    pulse_start(4'b1111);
    repeat (3) @(negedge clk);
    inp[0] = 1'b0;
    @(negedge clk);
    inp[0] = 1'b1;
    wait_done("t5_done_lat", 12);
    chk("t5_result", 32'(result), 32'b1100);
    repeat (3) @(negedge clk);

    // 6: reset mid-scan, then a fresh full scan
    pulse_start(4'b1111);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_sel",    32'({s1, s0}), 32'd0);
    chk("t6_busy",   32'(busy),     32'd0);
    chk("t6_result", 32'(result),   32'd0);
    chk("t6_valid",  32'(valid),    32'd0);
    dc0 = done_count;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_no_done", 32'(done_count - dc0), 32'd0);
    pulse_start(4'b1111);
    wait_done("t6_done_lat", 16);
    chk("t6_new_result", 32'(result), 32'b1101);
    chk("t6_new_valid",  32'(valid),  32'b1111);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
